// File: rtl/prog_loader.sv
// Serial bootloader: decodes 8N1 bytes from rx and writes a length-prefixed
// image of 16-bit little-endian words into program memory, then releases the MCU.
module prog_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [15:0]           pm_wdata,
  output logic                  mcu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int SYNC_STAGES = 2;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_COUNT,
    L_LO,
    L_HI,
    L_RUN,
    L_ERR
  } ld_state_t;

  // ---------------------------------------------------------------------
  // rx synchronizer (idles high so reset never looks like a start bit)
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  rx_state_t       rstate_reg, rstate_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      bitcnt_reg, bitcnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            byte_valid_reg, byte_valid_next;
  logic            frame_err_reg, frame_err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_reg     <= R_IDLE;
      timer_reg      <= '0;
      bitcnt_reg     <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rstate_reg     <= rstate_next;
      timer_reg      <= timer_next;
      bitcnt_reg     <= bitcnt_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    rstate_next     = rstate_reg;
    timer_next      = timer_reg + 1'b1;
    bitcnt_next     = bitcnt_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    unique case (rstate_reg)
      R_IDLE: begin
        timer_next = '0;
        if (!rx_s) begin
          rstate_next = R_START;
        end
      end
      R_START: begin
        // Mid-start-bit recheck; from here on samples land mid-bit.
        if (timer_reg == HALF_BIT) begin
          timer_next  = '0;
          bitcnt_next = '0;
          rstate_next = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (timer_reg == FULL_BIT) begin
          timer_next  = '0;
          shift_next  = {rx_s, shift_reg[7:1]};
          bitcnt_next = bitcnt_reg + 1'b1;
          if (bitcnt_reg == 3'd7) begin
            rstate_next = R_STOP;
          end
        end
      end
      R_STOP: begin
        if (timer_reg == FULL_BIT) begin
          timer_next      = '0;
          byte_valid_next = rx_s;
          frame_err_next  = !rx_s;
          rstate_next     = R_IDLE;
        end
      end
      default: begin
        rstate_next = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------
  ld_state_t             lstate_reg, lstate_next;
  logic [7:0]            remaining_reg, remaining_next;
  logic [7:0]            lo_reg, lo_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]           wdata_reg, wdata_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lstate_reg    <= L_COUNT;
      remaining_reg <= '0;
      lo_reg        <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      lstate_reg    <= lstate_next;
      remaining_reg <= remaining_next;
      lo_reg        <= lo_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  always_comb begin
    lstate_next    = lstate_reg;
    remaining_next = remaining_reg;
    lo_next        = lo_reg;
    we_next        = 1'b0;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;

    unique case (lstate_reg)
      L_COUNT: begin
        if (frame_err_reg) begin
          lstate_next = L_ERR;
        end else if (byte_valid_reg) begin
          if (shift_reg == 8'd0) begin
            lstate_next = L_RUN;
          end else begin
            remaining_next = shift_reg;
            addr_next      = '0;
            lstate_next    = L_LO;
          end
        end
      end
      L_LO: begin
        if (frame_err_reg) begin
          lstate_next = L_ERR;
        end else if (byte_valid_reg) begin
          lo_next     = shift_reg;
          lstate_next = L_HI;
        end
      end
      L_HI: begin
        // Stay in L_HI for the strobe cycle so the write lands while mcu_rst
        // is still high; advance the address only after the strobe.
        if (we_reg) begin
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 8'd1;
          lstate_next    = (remaining_reg == 8'd1) ? L_RUN : L_LO;
        end else if (frame_err_reg) begin
          lstate_next = L_ERR;
        end else if (byte_valid_reg) begin
          wdata_next = {shift_reg, lo_reg};
          we_next    = 1'b1;
        end
      end
      L_RUN: begin
        lstate_next = L_RUN;
      end
      L_ERR: begin
        lstate_next = L_ERR;
      end
      default: begin
        lstate_next = L_ERR;
      end
    endcase
  end

  assign pm_we    = we_reg;
  assign pm_addr  = addr_reg;
  assign pm_wdata = wdata_reg;
  assign mcu_rst  = (lstate_reg != L_RUN);
  assign done     = (lstate_reg == L_RUN);
  assign err      = (lstate_reg == L_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default instance and a 2-bit-address
// instance, with expected writes queued at stimulus time and popped on pm_we.
module tb_prog_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        rx2 = 1'b1;

  logic        pm_we, mcu_rst, done, err;
  logic [7:0]  pm_addr;
  logic [15:0] pm_wdata;

  logic        pm_we2, mcu_rst2, done2, err2;
  logic [1:0]  pm_addr2;
  logic [15:0] pm_wdata2;

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] exp_q  [$];
  logic [17:0] exp_q2 [$];
  logic [15:0] mem2 [4];

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .mcu_rst(mcu_rst), .done(done), .err(err)
  );

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2),
    .pm_we(pm_we2), .pm_addr(pm_addr2), .pm_wdata(pm_wdata2),
    .mcu_rst(mcu_rst2), .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (pm_we) begin
      chk("wr_while_mcu_run", {31'd0, mcu_rst}, 32'd1);
      chk("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("wr_addr_data", {8'd0, pm_addr, pm_wdata}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (pm_we2) begin
      mem2[pm_addr2] = pm_wdata2;
      chk("wr2_expected", {31'd0, exp_q2.size() != 0}, 32'd1);
      if (exp_q2.size() != 0) begin
        chk("wr2_addr_data", {14'd0, pm_addr2, pm_wdata2}, {14'd0, exp_q2.pop_front()});
      end
    end
  end

  task automatic set_line(input bit to2, input logic v);
    if (to2) rx2 = v;
    else     rx  = v;
  endtask

  task automatic wait_bit();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input bit to2, input logic [7:0] b, input logic stop);
    set_line(to2, 1'b0);
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      set_line(to2, b[i]);
      wait_bit();
    end
    set_line(to2, stop);
    wait_bit();
    set_line(to2, 1'b1);
    wait_bit();
    $display("sent byte %02h stop=%0d line=%0d", b, stop, to2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, pm_we},    32'd0);
    chk({tag, "_addr"},  {24'd0, pm_addr},  32'd0);
    chk({tag, "_wdata"}, {16'd0, pm_wdata}, 32'd0);
    chk({tag, "_mcurst"},{31'd0, mcu_rst},  32'd1);
    chk({tag, "_done"},  {31'd0, done},     32'd0);
    chk({tag, "_err"},   {31'd0, err},      32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state while held in reset.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    chk("rst2_mcurst", {31'd0, mcu_rst2}, 32'd1);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word image.
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    chk("img_mid_mcurst", {31'd0, mcu_rst}, 32'd1);
    chk("img_mid_addr",   {24'd0, pm_addr}, 32'd1);
    send_byte(0, 8'hCD, 1'b1);
    send_byte(0, 8'hAB, 1'b1);
    chk("img_mcurst", {31'd0, mcu_rst}, 32'd0);
    chk("img_done",   {31'd0, done},    32'd1);
    chk("img_err",    {31'd0, err},     32'd0);
    chk("img_addr",   {24'd0, pm_addr}, 32'd2);
    chk("img_hold",   {16'd0, pm_wdata}, 32'h0000ABCD);
    chk("img_q_empty", exp_q.size(), 32'd0);

    // Zero-length image.
    pulse_reset();
    send_byte(0, 8'h00, 1'b1);
    chk("zero_done",   {31'd0, done},    32'd1);
    chk("zero_mcurst", {31'd0, mcu_rst}, 32'd0);
    chk("zero_addr",   {24'd0, pm_addr}, 32'd0);

    // Framing error is sticky until reset.
    pulse_reset();
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h55, 1'b0);
    chk("ferr_err",    {31'd0, err},     32'd1);
    chk("ferr_mcurst", {31'd0, mcu_rst}, 32'd1);
    chk("ferr_done",   {31'd0, done},    32'd0);
    send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    chk("ferr_sticky_err",  {31'd0, err},     32'd1);
    chk("ferr_sticky_mcu",  {31'd0, mcu_rst}, 32'd1);
    chk("ferr_sticky_we",   {31'd0, pm_we},   32'd0);

    // Short low glitch on idle line.
    pulse_reset();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_reset_outputs("glitch");

    // Asynchronous reset in the middle of the second word's high byte.
    pulse_reset();
    exp_q.push_back({8'h00, 16'h1111});
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    chk("pre_rst_addr",  {24'd0, pm_addr},  32'd1);
    chk("pre_rst_wdata", {16'd0, pm_wdata}, 32'h00001111);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("async");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back({8'h00, 16'hBEEF});
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'hEF, 1'b1);
    send_byte(0, 8'hBE, 1'b1);
    chk("reload_done",   {31'd0, done},     32'd1);
    chk("reload_mcurst", {31'd0, mcu_rst},  32'd0);
    chk("reload_wdata",  {16'd0, pm_wdata}, 32'h0000BEEF);
    chk("reload_q_empty", exp_q.size(), 32'd0);

    // Address wrap on the 4-word instance.
    pulse_reset();
    send_byte(1, 8'h05, 1'b1);
    for (int w = 1; w <= 5; w++) begin
      logic [1:0] a;
      a = 2'(w - 1);
      exp_q2.push_back({a, 16'(w)});
      send_byte(1, 8'(w), 1'b1);
      if (w < 5) chk("wrap_mid_mcurst", {31'd0, mcu_rst2}, 32'd1);
      send_byte(1, 8'h00, 1'b1);
    end
    chk("wrap_done",   {31'd0, done2}, 32'd1);
    chk("wrap_err",    {31'd0, err2},  32'd0);
    chk("wrap_mem0",   {16'd0, mem2[0]}, 32'd5);
    chk("wrap_mem3",   {16'd0, mem2[3]}, 32'd4);
    chk("wrap_q_empty", exp_q2.size(), 32'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Serial bootloader that sits in front of the MicroController. It receives a program image over a UART-style line and writes it word by word into program memory. It holds the MCU in reset until the image is complete, then releases it. It is the writer end of the program memory that the MCU fetch path reads.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (even, >= 4).
ADDR_WIDTH, 8, program memory address width.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
rx  input  1  serial line, idle high, 8N1 framing, LSB first.
pm_we  output  1  program memory write strobe, one-cycle pulse.
pm_addr  output  ADDR_WIDTH  write address.
pm_wdata  output  16  write data.
mcu_rst  output  1  active-high reset to the MicroController.
done  output  1  image loaded, MCU running.
err  output  1  framing error latched.

Behaviour:
- Reset (rst=0, asynchronous) forces these values:
  - pm_we=0, pm_addr=0, pm_wdata=0.
  - mcu_rst=1, done=0, err=0.
  - All state is idle; rx sync flops are set to 1.
- rx passes through a 2-flop synchronizer. All decoding uses the synchronized value.
- Receiver FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE.
  - R_IDLE: a synced rx=0 enters R_START and clears the bit timer.
  - R_START: at timer = CLKS_PER_BIT/2-1, resample rx.
    - rx=1 is a glitch: return to R_IDLE with no byte and no error.
    - rx=0: enter R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into a byte register.
  - R_STOP: sample once after CLKS_PER_BIT.
    - rx=1: one-cycle byte_valid.
    - rx=0: one-cycle frame_err.
    - Both cases return to R_IDLE the next cycle, so back-to-back frames are accepted.
- Loader FSM: L_COUNT -> L_LO -> L_HI -> L_RUN, plus L_ERR.
  - L_COUNT: the first byte_valid latches word count N (8 bits).
    - N=0: go directly to L_RUN.
    - Otherwise go to L_LO with pm_addr=0 and remaining=N.
  - L_LO: byte_valid latches the low byte, then go to L_HI.
  - L_HI: byte_valid completes a word.
    - Next cycle: pm_wdata = {hi, lo}, pm_we=1 for exactly one cycle at the current pm_addr.
    - The cycle after the pulse: pm_addr increments and remaining decrements.
    - remaining reaching 0 -> L_RUN; otherwise -> L_LO.
  - L_RUN: mcu_rst=0 and done=1, asserted in the same cycle as the L_RUN entry.
    - Further rx bytes are still decoded but ignored.
    - Framing errors in L_RUN are ignored.
  - frame_err in L_COUNT, L_LO or L_HI enters L_ERR: err=1, mcu_rst stays 1, pm_we stays 0. L_ERR is left only by reset.
- pm_addr wraps modulo 2^ADDR_WIDTH when N exceeds the memory depth. Later words overwrite lower addresses; no error is raised.
- pm_wdata holds its last written value between strobes.
- mcu_rst is 1 in every state except L_RUN.
- Reset mid-frame or mid-image: the whole load is discarded and restarts at L_COUNT. Words already written stay in memory.
- The write pulse is never coincident with mcu_rst=0. The last write completes before or in the same cycle the loader leaves L_HI.

Test Plan:
- CLKS_PER_BIT=16. Send 0x02, 0x34, 0x12, 0xCD, 0xAB -> pm_we pulses twice: (addr 0, 0x1234), then (addr 1, 0xABCD). Then mcu_rst falls to 0 and done=1; err stays 0.
- Send count 0x00 -> no pm_we pulse; mcu_rst=0 and done=1 within 2 cycles of byte completion.
- Send 0x01, then a 0x55 frame with stop bit 0 -> err=1, mcu_rst=1, no pm_we. A later valid frame causes no change until rst is pulsed low.
- Hold rx low for 4 cycles in idle, then return high -> no byte_valid, loader stays in L_COUNT, all outputs at reset values.
- Assert rst low during the second word's high byte -> all outputs reset asynchronously. Reloading image 0x01, 0xEF, 0xBE writes 0xBEEF at addr 0 and releases mcu_rst.
- ADDR_WIDTH=2, N=5 with words 0x0001..0x0005 -> writes go to addrs 0,1,2,3,0. Final memory[0]=0x0005, then done=1.
